// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory arbitration path.
//   arb_state_t : arbiter FSM states
//   owner_t     : which cache owns (or last owned) the memory port
//   LINE_BITS / BEAT_BITS / BEATS : cacheline and burst geometry
//   line_base() : aligns a byte address to its cacheline base
package cache_mem_types;

  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned BEAT_BITS = 64;
  localparam int unsigned BEATS     = LINE_BITS / BEAT_BITS;

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } owner_t;

  // 32-byte lines: the low five address bits are dropped.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'h0000_001F;
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Beat sequencing between a 256-bit cacheline and a 64-bit burst port.
//   start      : clear the beat counter (new burst granted)
//   load_wdata : latch wline as the outgoing writeback line
//   beat_ack   : memory accepted/returned the current beat
//   capture    : current burst is a read, store mem_rdata at beat k
//   mem_wdata  : outgoing beat k of the latched writeback line
//   rline      : assembled read line
//   done       : beat_ack on the final beat
module cacheline_adapter
  import cache_mem_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load_wdata,
  input  logic [LINE_BITS-1:0] wline,
  input  logic                 beat_ack,
  input  logic                 capture,
  input  logic [BEAT_BITS-1:0] mem_rdata,
  output logic [BEAT_BITS-1:0] mem_wdata,
  output logic [LINE_BITS-1:0] rline,
  output logic                 done
);

  localparam int unsigned CNT_BITS = $clog2(BEATS);

  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [LINE_BITS-1:0] rbuf_q, rbuf_d;
  logic [LINE_BITS-1:0] wbuf_q, wbuf_d;
  logic                 last_beat;

  // Read and write lines are kept apart so a writeback never disturbs the
  // last read line still presented to the caches.
  always_comb begin
    cnt_d     = cnt_q;
    rbuf_d    = rbuf_q;
    wbuf_d    = wbuf_q;
    mem_wdata = '0;

    if (start) begin
      cnt_d = '0;
    end else if (beat_ack) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (load_wdata) begin
      wbuf_d = wline;
    end

    for (int unsigned b = 0; b < BEATS; b++) begin
      if (cnt_q == CNT_BITS'(b)) begin
        mem_wdata = wbuf_q[b*BEAT_BITS +: BEAT_BITS];
        if (beat_ack && capture) begin
          rbuf_d[b*BEAT_BITS +: BEAT_BITS] = mem_rdata;
        end
      end
    end

    last_beat = (cnt_q == CNT_BITS'(BEATS - 1));
    done      = beat_ack && last_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      rbuf_q <= '0;
      wbuf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rbuf_q <= rbuf_d;
      wbuf_q <= wbuf_d;
    end
  end

  assign rline = rbuf_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one burst memory port between the I-cache and the D-cache.
// Each granted cacheline request becomes a 4-beat 64-bit burst; the
// assembled line and a one-cycle resp pulse go back to the owner.
//   i_pmem_*  : I-cache line-read port (read, address, rdata, resp)
//   d_pmem_*  : D-cache line read/writeback port
//   mem_*     : burst memory port (read/write request, base address,
//               write beat, per-beat resp, read beat)
module cache_arbiter
  import cache_mem_types::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_pmem_read,
  input  logic [31:0]          i_pmem_address,
  output logic [LINE_BITS-1:0] i_pmem_rdata,
  output logic                 i_pmem_resp,

  input  logic                 d_pmem_read,
  input  logic                 d_pmem_write,
  input  logic [31:0]          d_pmem_address,
  input  logic [LINE_BITS-1:0] d_pmem_wdata,
  output logic [LINE_BITS-1:0] d_pmem_rdata,
  output logic                 d_pmem_resp,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [BEAT_BITS-1:0] mem_wdata,
  input  logic                 mem_resp,
  input  logic [BEAT_BITS-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  // Owner of the current burst; after completion it is the last grant and
  // drives the fairness rule. Resets to I so D wins the first contention.
  owner_t     owner_q, owner_d;

  logic [31:0] addr_q, addr_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        i_resp_q, i_resp_d;
  logic        d_resp_q, d_resp_d;

  logic                 start, load_wdata;
  logic                 in_xfer, capture, beat_ack, done;
  logic                 d_req, grant_d;
  logic [LINE_BITS-1:0] rline;

  assign in_xfer  = (state_q == I_READ) || (state_q == D_READ) || (state_q == D_WRITE);
  assign capture  = (state_q == I_READ) || (state_q == D_READ);
  assign beat_ack = mem_resp && in_xfer;

  assign d_req   = d_pmem_read || d_pmem_write;
  // D wins unless it had the previous grant and I is waiting.
  assign grant_d = d_req && !((owner_q == OWNER_D) && i_pmem_read);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_resp_d    = 1'b0;
    d_resp_d    = 1'b0;
    start       = 1'b0;
    load_wdata  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          start   = 1'b1;
          owner_d = OWNER_D;
          addr_d  = line_base(d_pmem_address);
          if (d_pmem_write) begin
            state_d     = D_WRITE;
            mem_write_d = 1'b1;
            load_wdata  = 1'b1;
          end else begin
            state_d    = D_READ;
            mem_read_d = 1'b1;
          end
        end else if (i_pmem_read) begin
          start      = 1'b1;
          owner_d    = OWNER_I;
          addr_d     = line_base(i_pmem_address);
          state_d    = I_READ;
          mem_read_d = 1'b1;
        end
      end

      I_READ, D_READ, D_WRITE: begin
        if (done) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (owner_q == OWNER_I) begin
            i_resp_d = 1'b1;
          end else begin
            d_resp_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_I;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
    end
  end

  cacheline_adapter u_adapter (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_wdata (load_wdata),
    .wline      (d_pmem_wdata),
    .beat_ack   (beat_ack),
    .capture    (capture),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .rline      (rline),
    .done       (done)
  );

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = addr_q;
  assign i_pmem_resp  = i_resp_q;
  assign d_pmem_resp  = d_resp_q;
  assign i_pmem_rdata = rline;
  assign d_pmem_rdata = rline;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  import cache_mem_types::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         mem_resp;
  logic [63:0]  mem_rdata;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata)
  );

  typedef struct {
    bit           own_d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } sb_t;

  typedef struct {
    bit           i_rd;
    bit           d_rd;
    bit           d_wr;
    logic [31:0]  i_addr;
    logic [31:0]  d_addr;
    logic [255:0] wline;
    int unsigned  lat;
    int unsigned  gap;
    int unsigned  exp_lat;
  } vec_t;

  sb_t          sb[$];
  vec_t         vecs[7];
  int unsigned  n_vec = 0;
  int unsigned  n_miss = 0;
  int unsigned  n_resp_mon = 0;
  int unsigned  n_resp_exp = 0;
  bit           last_d_model = 1'b0;
  logic [255:0] last_rd_line = '0;
  int unsigned  mem_lat = 0;
  int unsigned  mem_gap = 0;
  bit           spurious = 1'b0;
  int unsigned  mk = 0;
  int unsigned  wait_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s", name);
  endtask

  // Memory contents: beat k of a line is a repeated byte (k+1)*0x11 mixed
  // with the address, so line 0x1220 reads back as 0x11..,0x22..,...
  function automatic logic [63:0] beat(input logic [31:0] a, input int unsigned k);
    logic [7:0]  b;
    logic [31:0] m;
    b = 8'((k + 1) * 17);
    m = a ^ 32'h0000_1220;
    return {8{b}} ^ {m, m};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    for (int unsigned k = 0; k < 4; k++) l[k*64 +: 64] = beat(a, k);
    return l;
  endfunction

  function automatic sb_t mk_entry(input bit own_d, input bit wr, input logic [31:0] a,
                                   input logic [255:0] wl);
    sb_t e;
    e.own_d = own_d;
    e.wr    = wr;
    e.addr  = a & ~32'h1F;
    e.line  = wr ? wl : exp_line(a & ~32'h1F);
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst !== 1'b1)
      assert (!(d_pmem_read && d_pmem_write)) else $error("d read and write both high");
  end

  always @(posedge clk) begin
    #1;
    if (i_pmem_resp === 1'b1) n_resp_mon++;
    if (d_pmem_resp === 1'b1) n_resp_mon++;
  end

  // Memory model: acks beats after mem_lat idle cycles, mem_gap cycles apart.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_resp = 1'b0;
        mk       = 0;
        wait_cnt = mem_lat;
      end else if (mem_read || mem_write) begin
        if (wait_cnt > 0) begin
          mem_resp = 1'b0;
          wait_cnt--;
        end else if (sb.size() == 0) begin
          mem_resp = 1'b0;
          fail_now("burst_unexpected");
        end else begin
          check("mem_addr", mem_addr, sb[0].addr);
          check("mem_dir", {mem_read, mem_write}, sb[0].wr ? 2'b01 : 2'b10);
          if (sb[0].wr) check("mem_wdata", mem_wdata, sb[0].line[mk*64 +: 64]);
          mem_resp  = 1'b1;
          mem_rdata = beat(mem_addr, mk);
          mk++;
          wait_cnt = mem_gap;
        end
      end else begin
        mem_resp  = spurious;
        mem_rdata = spurious ? {$urandom, $urandom} : 64'h0;
        mk        = 0;
        wait_cnt  = mem_lat;
      end
    end
  end

  task automatic pop_check(input bit own_d);
    sb_t e;
    if (sb.size() == 0) begin
      fail_now("resp_unexpected");
      return;
    end
    e = sb.pop_front();
    n_resp_exp++;
    check("resp_owner", own_d, e.own_d);
    if (e.wr) begin
      check("rdata_hold", d_pmem_rdata, last_rd_line);
    end else begin
      if (own_d) check("d_rdata", d_pmem_rdata, e.line);
      else       check("i_rdata", i_pmem_rdata, e.line);
      last_rd_line = e.line;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit tail);
    bit          i_done, d_done, d_pend, d_first;
    int unsigned n;
    mem_lat = v.lat;
    mem_gap = v.gap;
    d_pend  = v.d_rd || v.d_wr;
    d_first = d_pend && !(last_d_model && v.i_rd);
    if (d_first) begin
      sb.push_back(mk_entry(1'b1, v.d_wr, v.d_addr, v.wline));
      if (v.i_rd) sb.push_back(mk_entry(1'b0, 1'b0, v.i_addr, '0));
    end else begin
      if (v.i_rd) sb.push_back(mk_entry(1'b0, 1'b0, v.i_addr, '0));
      if (d_pend) sb.push_back(mk_entry(1'b1, v.d_wr, v.d_addr, v.wline));
    end
    last_d_model = sb[sb.size()-1].own_d;

    @(posedge clk); #1;
    i_pmem_read    = v.i_rd;
    i_pmem_address = v.i_addr;
    d_pmem_read    = v.d_rd;
    d_pmem_write   = v.d_wr;
    d_pmem_address = v.d_addr;
    d_pmem_wdata   = v.wline;
    i_done = !v.i_rd;
    d_done = !d_pend;
    n = 0;
    while (!(i_done && d_done) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (i_pmem_resp) begin
        if (i_done) fail_now("i_resp_extra");
        else begin
          i_done = 1'b1;
          pop_check(1'b0);
          i_pmem_read = 1'b0;
          if (v.exp_lat != 0) check("i_latency", n, v.exp_lat);
        end
      end
      if (d_pmem_resp) begin
        if (d_done) fail_now("d_resp_extra");
        else begin
          d_done = 1'b1;
          pop_check(1'b1);
          d_pmem_read  = 1'b0;
          d_pmem_write = 1'b0;
          if (v.exp_lat != 0) check("d_latency", n, v.exp_lat);
        end
      end
    end
    if (!(i_done && d_done)) begin
      fail_now("resp_timeout");
      i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      sb.delete();
    end
    if (tail) begin
      @(posedge clk); #1;
      check("resp_pulse", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_rw"}, {mem_read, mem_write}, 2'b00);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    check({tag, "_resp"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
    check({tag, "_i_rdata"}, i_pmem_rdata, '0);
    check({tag, "_d_rdata"}, d_pmem_rdata, '0);
  endtask

  initial begin
    logic [255:0] wl_idx, wl_rnd;
    vec_t         v;
    int unsigned  n;

    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;

    for (int w = 0; w < 8; w++) wl_idx[w*32 +: 32] = 32'(w);
    for (int w = 0; w < 8; w++) wl_rnd[w*32 +: 32] = $urandom;

    //            i  d  w  i_addr        d_addr        wline   lat gap exp_lat
    vecs[0] = '{1, 0, 0, 32'h0000_1234, 32'h0,        '0,     0,  0,  5};
    vecs[1] = '{0, 0, 1, 32'h0,        32'h0000_8040, wl_idx, 0,  2,  11};
    vecs[2] = '{1, 0, 0, 32'hABCD_EF1F, 32'h0,        '0,     1,  0,  6};
    vecs[3] = '{1, 1, 0, 32'h0000_2000, 32'h0000_3000, '0,    0,  1,  0};
    vecs[4] = '{1, 1, 0, 32'h0000_2100, 32'h0000_3108, '0,    2,  0,  0};
    vecs[5] = '{0, 0, 1, 32'h0,        32'hFFFF_FFE0, wl_rnd, 3,  1,  11};
    vecs[6] = '{1, 0, 0, 32'hFFFF_FFFF, 32'h0,        '0,     0,  0,  5};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

    // D re-requests in the IDLE cycle straight after its resp.
    v = '{0, 1, 0, 32'h0, 32'h0000_5500, '0, 0, 0, 5};
    run_vec(v, 1'b0);
    v.d_addr = 32'h0000_5520;
    run_vec(v, 1'b1);

    // Stray beat acks while idle must not move anything.
    spurious = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("spur_rw", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    end
    spurious = 1'b0;
    check("spur_i_rdata", i_pmem_rdata, last_rd_line);
    check("spur_d_rdata", d_pmem_rdata, last_rd_line);
    v = '{1, 0, 0, 32'h0000_7777, 32'h0, '0, 0, 0, 5};
    run_vec(v, 1'b1);

    // Reset in the middle of an I read after two beats.
    mem_lat = 0;
    mem_gap = 1;
    sb.push_back(mk_entry(1'b0, 1'b0, 32'h0000_4440, '0));
    @(posedge clk); #1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_4440;
    n = 0;
    while (mk < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (mk < 2) fail_now("rst_wait_timeout");
    check("pre_rst_mem_read", mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
    i_pmem_read = 1'b0;
    sb.delete();
    last_d_model = 1'b0;
    last_rd_line = '0;
    rst = 1'b0;
    v = '{1, 0, 0, 32'h0000_4440, 32'h0, '0, 0, 0, 5};
    run_vec(v, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("resp_total", n_resp_mon, n_resp_exp);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single burst memory port between the instruction cache and the data cache. Each cache issues a whole-cacheline (256-bit) read or write on its pmem-side port. The arbiter grants one request at a time and converts it into a 4-beat, 64-bit burst on the memory port. It then returns the assembled line together with a one-cycle response pulse to the granted cache. It sits directly downstream of `i_cache`/`d_cache` and upstream of physical memory inside `mp4`.

## Interface
- `LINE_BITS`, 256, cacheline width.
- `BEAT_BITS`, 64, burst beat width; BEATS = LINE_BITS/BEAT_BITS = 4.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `i_pmem_read`  in  1  I-cache line-read request, held until `i_pmem_resp`.
- `i_pmem_address`  in  32  I-cache line address.
- `i_pmem_rdata`  out  256  returned line, valid while `i_pmem_resp`.
- `i_pmem_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_pmem_read`  in  1  D-cache line-read request, held until `d_pmem_resp`.
- `d_pmem_write`  in  1  D-cache line-writeback request, held until `d_pmem_resp`.
- `d_pmem_address`  in  32  D-cache line address.
- `d_pmem_wdata`  in  256  writeback line.
- `d_pmem_rdata`  out  256  returned line, valid while `d_pmem_resp`.
- `d_pmem_resp`  out  1  one-cycle completion pulse to D-cache.
- `mem_read`  out  1  burst read request.
- `mem_write`  out  1  burst write request.
- `mem_addr`  out  32  burst base address, bits [4:0] always 0.
- `mem_wdata`  out  64  current write beat.
- `mem_resp`  in  1  beat acknowledge, one per beat.
- `mem_rdata`  in  64  current read beat.

## Operation
- States: IDLE, I_READ, D_READ, D_WRITE, DONE.
- IDLE: arbitrate among the pending requests.
  - D requests win by default.
  - Exception: when the previous grant went to D and `i_pmem_read` is pending, I wins. Both caches pending therefore alternate, and neither can starve.
  - `d_pmem_write` takes precedence over `d_pmem_read` if both are high. This case is illegal for the client; the bench asserts on it.
- On grant, latch the owner, `{addr[31:5],5'b0}` and, for writes, `d_pmem_wdata`. Clear the beat counter. Client inputs are ignored until DONE.
- Transfer states:
  - Hold `mem_read` (or `mem_write`) and `mem_addr` steady.
  - Each cycle with `mem_resp`=1, capture `mem_rdata` into line bits [64k+63:64k] (read), with k = beat counter. Then increment k.
  - `mem_wdata` = latched line[64k+63:64k], combinational from k.
  - Beats need not be consecutive.
  - The state exits to DONE on the edge that accepts beat 3.
- DONE (exactly one cycle):
  - Request lines low.
  - Owner's `*_pmem_resp`=1.
  - Both `*_pmem_rdata` drive the line buffer; it is meaningful for reads only.
  - Next state is IDLE.
- The client drops its request on the edge after its resp. IDLE therefore never re-serves a finished request.
- `mem_resp` outside a transfer state is ignored.

## Timing
- Reset, asynchronous: state IDLE, counter 0, line buffer 0, last-grant = I. All outputs 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, both resp, both rdata.
- Reset mid-burst: abandon the burst immediately. No resp is issued, and the memory request drops in the same cycle as reset.
- Request seen in IDLE at cycle t → `mem_read`/`mem_write` high from cycle t+1.
- First `mem_resp` at t+1+L, beats consecutive → resp at cycle t+5+L.
  - Minimum request-to-resp latency is 5 cycles.
  - Back-to-back grants have a minimum of 6 cycles between grants (one IDLE cycle).
- `*_pmem_rdata` holds its value after resp until the next read completes.

## Structure
- Shared package `cache_mem_types`:
  - State enum `arb_state_t`.
  - Owner enum {I, D}.
  - Constants LINE_BITS, BEAT_BITS, BEATS.
- Sub-module `cacheline_adapter`:
  - Holds the 2-bit beat counter, the line buffer, beat-select for `mem_wdata`, and the last-beat flag.
  - The arbiter FSM drives its start/load and consumes its done flag.

## Test plan
- I read alone:
  - Stimulus: `i_pmem_address`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with L=0.
  - Response: `mem_addr`=0x0000_1220; `i_pmem_rdata`={0x44..,0x33..,0x22..,0x11..}; `i_pmem_resp` is a single pulse at t+5; `d_pmem_resp` stays 0.
- D write:
  - Stimulus: `d_pmem_wdata` = line with word i = i; `mem_resp` gaps of 2 cycles between beats.
  - Response: `mem_wdata` on the four acked cycles = line[63:0], [127:64], [191:128], [255:192]; `mem_write` stays high throughout the gaps.
- Simultaneous I read + D read, twice in succession:
  - Response: grants go D, I, D, I.
  - I is served right after each D, and each client receives its own data.
- Back-to-back:
  - Stimulus: D re-requests on the cycle after its resp.
  - Response: one IDLE cycle, then a new burst; no duplicate resp.
- Reset asserted after beat 2 of a read:
  - Response: outputs are 0 asynchronously, no resp is issued, and the next request after reset completes normally.
- Spurious `mem_resp` pulses while in IDLE:
  - Response: no state change; the buffer is unchanged.
